// File: rtl/mem_arbiter.sv
// Two-port (fetch / MEM-stage) to one-port memory arbiter with per-port stall generation.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of D-over-I priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  cmd_read_q, cmd_read_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic done;
  logic done_i;
  logic done_d;

  always_comb begin
    i_req  = I_READ;
    d_req  = D_READ | D_WRITE;
    done   = (state_q != IDLE) & ~MEM_BUSYWAIT;
    done_i = (state_q == GRANT_I) & ~MEM_BUSYWAIT;
    done_d = (state_q == GRANT_D) & ~MEM_BUSYWAIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_d = d_req & (~i_req | ~last_grant_q);
`else
    pick_d = d_req;
`endif
  end

  // Command flags are cleared on the way back to IDLE, so MEM_READ/MEM_WRITE
  // come straight from flops and are zero whenever no grant is active.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_read_d   = cmd_read_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = GRANT_D;
          cmd_read_d  = D_READ & ~D_WRITE;
          cmd_write_d = D_WRITE;
          cmd_addr_d  = D_ADDRESS;
          cmd_wdata_d = D_WRITEDATA;
        end else if (i_req) begin
          state_d     = GRANT_I;
          cmd_read_d  = 1'b1;
          cmd_write_d = 1'b0;
          cmd_addr_d  = I_ADDRESS;
          cmd_wdata_d = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (done) begin
          state_d      = IDLE;
          last_grant_d = (state_q == GRANT_D);
          cmd_read_d   = 1'b0;
          cmd_write_d  = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_read_d  = 1'b0;
        cmd_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cmd_read_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_read_q   <= cmd_read_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  always_comb begin
    MEM_READ      = cmd_read_q;
    MEM_WRITE     = cmd_write_q;
    MEM_ADDRESS   = cmd_addr_q;
    MEM_WRITEDATA = cmd_wdata_q;
    I_BUSYWAIT    = i_req & ~done_i;
    D_BUSYWAIT    = d_req & ~done_d;
    I_READDATA    = done_i ? MEM_READDATA : '0;
    D_READDATA    = (done_d & cmd_read_q) ? MEM_READDATA : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against
// a cycle-level reference model and a small behavioural backing memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [DW-1:0] I_READDATA;
  logic          I_BUSYWAIT;
  logic          D_READ, D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [DW-1:0] D_WRITEDATA;
  logic [DW-1:0] D_READDATA;
  logic          D_BUSYWAIT;
  logic          MEM_READ, MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITEDATA;
  logic [DW-1:0] MEM_READDATA;
  logic          MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the memory (-1 none, 0 fetch, 1 data) and the accepted command.
  int          m_owner;
  bit          m_last;
  bit          m_rd, m_wr;
  logic [31:0] m_addr, m_wdata;

  // Backing memory: 16 words, latency chosen per transaction.
  logic [31:0] mem [16];
  int          mem_cnt, cur_lat, lat_next;
  bit          mem_busy;

  int          cyc;
  int          i_ack_cyc, d_ack_cyc;
  bit          i_ack, d_ack;
  logic [31:0] d_ack_rdata;
  logic [31:0] issued [$];

  task automatic cycle();
    logic       active;
    logic [3:0] idx;
    bit         done, pi, pd;
    logic [31:0] exp_i, exp_d;
    active = MEM_READ || MEM_WRITE;
    if (active && mem_cnt == 0) begin
      cur_lat = lat_next;
      issued.push_back(MEM_ADDRESS);
    end
    mem_busy     = active && (mem_cnt < cur_lat - 1);
    idx          = MEM_ADDRESS[5:2];
    MEM_BUSYWAIT = mem_busy;
    MEM_READDATA = (MEM_READ && !mem_busy) ? mem[idx] : $urandom;
    @(negedge CLK);
    done  = (m_owner >= 0) && !mem_busy;
    exp_i = (m_owner == 0 && done) ? mem[I_ADDRESS[5:2]] : 32'd0;
    exp_d = (m_owner == 1 && done && m_rd) ? mem[D_ADDRESS[5:2]] : 32'd0;
    check_eq("mem_read",  32'(MEM_READ),  32'(m_owner >= 0 && m_rd));
    check_eq("mem_write", 32'(MEM_WRITE), 32'(m_owner >= 0 && m_wr));
    if (m_owner >= 0) check_eq("mem_addr", MEM_ADDRESS, m_addr);
    if (m_owner >= 0 && m_wr) check_eq("mem_wdata", MEM_WRITEDATA, m_wdata);
    check_eq("i_busywait", 32'(I_BUSYWAIT), 32'(I_READ && !(m_owner == 0 && done)));
    check_eq("d_busywait", 32'(D_BUSYWAIT), 32'((D_READ || D_WRITE) && !(m_owner == 1 && done)));
    check_eq("i_readdata", I_READDATA, exp_i);
    check_eq("d_readdata", D_READDATA, exp_d);
    i_ack = I_READ && !I_BUSYWAIT;
    d_ack = (D_READ || D_WRITE) && !D_BUSYWAIT;
    if (i_ack) i_ack_cyc = cyc;
    if (d_ack) begin
      d_ack_cyc   = cyc;
      d_ack_rdata = D_READDATA;
    end
    if (MEM_WRITE && !mem_busy) mem[idx] = MEM_WRITEDATA;
    mem_cnt = (active && mem_busy) ? mem_cnt + 1 : 0;
    pi = I_READ;
    pd = D_READ || D_WRITE;
    if (RESET) begin
      m_owner = -1; m_last = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    end else if (m_owner < 0) begin
      if (pd && (!pi || !RR || !m_last)) begin
        m_owner = 1; m_wr = D_WRITE; m_rd = D_READ && !D_WRITE;
        m_addr = D_ADDRESS; m_wdata = D_WRITEDATA;
      end else if (pi) begin
        m_owner = 0; m_rd = 1; m_wr = 0; m_addr = I_ADDRESS; m_wdata = 0;
      end
    end else if (done) begin
      m_last  = (m_owner == 1);
      m_owner = -1;
    end
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  // Pipeline-like requester: drops a request once it has been serviced.
  task automatic cycle_dir();
    cycle();
    if (i_ack) I_READ = 1'b0;
    if (d_ack) begin
      D_READ  = 1'b0;
      D_WRITE = 1'b0;
    end
  endtask

  initial begin
    int t0;
    RESET = 1'b1; I_READ = 0; I_ADDRESS = 0; D_READ = 0; D_WRITE = 0;
    D_ADDRESS = 0; D_WRITEDATA = 0; MEM_READDATA = 0; MEM_BUSYWAIT = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    m_owner = -1; m_last = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    mem_cnt = 0; cur_lat = 1; lat_next = 1; cyc = 0;
    i_ack = 0; d_ack = 0; i_ack_cyc = -1; d_ack_cyc = -1; d_ack_rdata = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_mem_read",  32'(MEM_READ), 0);
    check_eq("rst_mem_write", 32'(MEM_WRITE), 0);
    check_eq("rst_mem_addr",  MEM_ADDRESS, 0);
    check_eq("rst_mem_wdata", MEM_WRITEDATA, 0);
    check_eq("rst_i_rdata",   I_READDATA, 0);
    check_eq("rst_d_rdata",   D_READDATA, 0);
    RESET = 1'b0;
    cycle_dir();

    // Fetch read, latency 3.
    I_READ = 1; I_ADDRESS = 32'h10; lat_next = 3; t0 = cyc; i_ack_cyc = -1;
    cycle_dir();
    check_eq("a_issue_read", 32'(MEM_READ), 1);
    check_eq("a_issue_addr", MEM_ADDRESS, 32'h10);
    repeat (3) cycle_dir();
    check_eq("a_ack_cycle", 32'(i_ack_cyc - t0), 3);
    check_eq("a_idle_read", 32'(MEM_READ), 0);
    cycle_dir();

    // Simultaneous fetch and load, latency 2: load first.
    I_READ = 1; I_ADDRESS = 32'h20; D_READ = 1; D_ADDRESS = 32'h100; lat_next = 2;
    t0 = cyc; i_ack_cyc = -1; d_ack_cyc = -1;
    cycle_dir();
    check_eq("b_first_addr", MEM_ADDRESS, 32'h100);
    repeat (6) cycle_dir();
    check_eq("b_d_ack_cycle", 32'(d_ack_cyc - t0), 2);
    check_eq("b_i_ack_cycle", 32'(i_ack_cyc - t0), 5);

    // Store with read also asserted: write wins.
    D_READ = 1; D_WRITE = 1; D_ADDRESS = 32'h200; D_WRITEDATA = 32'hDEADBEEF; lat_next = 2;
    t0 = cyc; d_ack_cyc = -1; d_ack_rdata = 32'hFFFF_FFFF;
    cycle_dir();
    check_eq("c_write", 32'(MEM_WRITE), 1);
    check_eq("c_read",  32'(MEM_READ), 0);
    check_eq("c_wdata", MEM_WRITEDATA, 32'hDEADBEEF);
    repeat (3) cycle_dir();
    check_eq("c_ack_cycle", 32'(d_ack_cyc - t0), 2);
    check_eq("c_rdata_zero", d_ack_rdata, 0);
    check_eq("c_mem_stored", mem[0], 32'hDEADBEEF);

    // Reset in the second cycle of a fetch grant with memory still busy.
    I_READ = 1; I_ADDRESS = 32'h30; lat_next = 4; t0 = cyc; i_ack_cyc = -1;
    cycle_dir();
    cycle_dir();
    RESET = 1;
    cycle_dir();
    RESET = 0;
    check_eq("d_rst_read",   32'(MEM_READ), 0);
    check_eq("d_rst_addr",   MEM_ADDRESS, 0);
    check_eq("d_rst_wdata",  MEM_WRITEDATA, 0);
    check_eq("d_rst_i_bw",   32'(I_BUSYWAIT), 1);
    check_eq("d_rst_i_rdata", I_READDATA, 0);
    for (int k = 0; k < 12 && i_ack_cyc < 0; k++) cycle_dir();
    check_eq("d_recover_cycle", 32'(i_ack_cyc - t0), 7);
    cycle_dir();

    // Both ports requesting continuously, latency 1.
    I_READ = 1; I_ADDRESS = 32'h40; D_READ = 1; D_ADDRESS = 32'h80; lat_next = 1;
    issued.delete();
    repeat (12) cycle();
    check_eq("e_grant_count", 32'(issued.size()), 6);
    for (int k = 0; k < 6 && k < issued.size(); k++)
      check_eq($sformatf("e_grant%0d", k), issued[k], (RR && (k % 2 == 1)) ? 32'h40 : 32'h80);
    I_READ = 0; D_READ = 0;
    repeat (2) cycle_dir();

    // Memory completes in the first grant cycle.
    D_READ = 1; D_ADDRESS = 32'h44; lat_next = 1; t0 = cyc; d_ack_cyc = -1;
    repeat (3) cycle_dir();
    check_eq("f_ack_cycle", 32'(d_ack_cyc - t0), 1);
    check_eq("f_rdata", d_ack_rdata, mem[1]);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (!I_READ || i_ack) begin
        I_READ    = ($urandom_range(0, 3) != 0);
        I_ADDRESS = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!(D_READ || D_WRITE) || d_ack) begin
        case ($urandom_range(0, 5))
          0:       begin D_READ = 0; D_WRITE = 0; end
          1, 2:    begin D_READ = 1; D_WRITE = 0; end
          3, 4:    begin D_READ = 0; D_WRITE = 1; end
          default: begin D_READ = 1; D_WRITE = 1; end
        endcase
        D_ADDRESS   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        D_WRITEDATA = $urandom;
      end
      lat_next = $urandom_range(1, 4);
      RESET    = ($urandom_range(0, 299) == 0);
    end
    RESET = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter between the instruction-fetch port and the data-memory (MEM stage) port of the pipelined RV32IM core, sharing a single backing memory. It serialises requests and latches the granted command. It generates the per-port busywait signals that stall the pipeline registers. It sits between the CPU's fetch and MEM-stage memory interfaces and the unified main memory.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- CLK  in  1  system clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- I_READ  in  1  fetch read request, held until I_BUSYWAIT low
- I_ADDRESS  in  ADDR_WIDTH  fetch address
- I_READDATA  out  DATA_WIDTH  fetched word, valid in completion cycle
- I_BUSYWAIT  out  1  fetch stall
- D_READ, D_WRITE  in  1 each  data request, held until D_BUSYWAIT low
- D_ADDRESS  in  ADDR_WIDTH  data address
- D_WRITEDATA  in  DATA_WIDTH  store data
- D_READDATA  out  DATA_WIDTH  load data, valid in completion cycle
- D_BUSYWAIT  out  1  MEM-stage stall
- MEM_READ, MEM_WRITE  out  1 each  backing-memory command
- MEM_ADDRESS  out  ADDR_WIDTH  backing-memory address
- MEM_WRITEDATA  out  DATA_WIDTH  backing-memory store data
- MEM_READDATA  in  DATA_WIDTH  backing-memory read data
- MEM_BUSYWAIT  in  1  high while the memory transaction is in progress; low in the completion cycle

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D. Register LAST_GRANT (0=I, 1=D).
- IDLE: MEM_READ=MEM_WRITE=0. Arbitrate on the current requests:
  - only D pending -> GRANT_D
  - only I pending -> GRANT_I
  - both pending -> GRANT_D (fixed priority; MEM stage holds the older instruction)
  - none pending -> stay in IDLE
- On entering a GRANT state, latch the command registers:
  - read flag, write flag, address, write data of the granted port
  - D_READ and D_WRITE both high: write latched, read ignored
- GRANT_x: MEM_READ, MEM_WRITE, MEM_ADDRESS and MEM_WRITEDATA are driven only from the latched registers.
- Completion = GRANT_x and MEM_BUSYWAIT=0. On completion, return to IDLE at the next edge and update LAST_GRANT.
- Busywait outputs:
  - I_BUSYWAIT = I_READ and not (GRANT_I and completion)
  - D_BUSYWAIT = (D_READ or D_WRITE) and not (GRANT_D and completion)
  - A port with no request never sees busywait.
- Read data: I_READDATA / D_READDATA = MEM_READDATA in the owning port's completion cycle; 0 otherwise.
- A granted requester dropping its request mid-grant is a protocol violation. The latched transaction still runs to completion; the result is discarded.
- A transaction in flight is never aborted except by RESET.

## Timing
- Reset: state=IDLE, LAST_GRANT=0, latched registers=0. MEM_READ=MEM_WRITE=0, MEM_ADDRESS=MEM_WRITEDATA=0, I_READDATA=D_READDATA=0.
- RESET asserted in any state (including mid-grant) -> IDLE at that edge. Memory command drops in the following cycle.
- Cycle timeline:
  - Request seen in IDLE at cycle n -> MEM command visible in cycle n+1.
  - Earliest completion is cycle n+1 (memory keeps busywait low); then requester busywait is low in n+1.
- Minimum 2 cycles per transaction. Each transaction is followed by one IDLE cycle before the next grant, so back-to-back requests are issued every (memory latency + 1) cycles.
- Simultaneous requests: D completes first. I is granted in the IDLE cycle after D completes; I_BUSYWAIT stays high throughout.
- MEM outputs are registered/state-derived: no combinational path from requester inputs to MEM_*.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: when both ports are pending in IDLE, grant the port opposite to LAST_GRANT.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed D-over-I priority; LAST_GRANT is still maintained but unused.

## Test plan
- I_READ at 0x0000_0010, memory latency 3 (MEM_BUSYWAIT high for 2 grant cycles) -> MEM_READ=1 with MEM_ADDRESS=0x10 from cycle 1. I_BUSYWAIT low in cycle 3 with I_READDATA=memory word. IDLE in cycle 4.
- I_READ@0x20 and D_READ@0x100 in the same cycle, latency 2 -> 0x100 issued first; D_BUSYWAIT falls in cycle 2. 0x20 issued in cycle 4; I_BUSYWAIT falls in cycle 5.
- D_WRITE@0x200, data 0xDEADBEEF, with D_READ also high -> MEM_WRITE=1, MEM_READ=0, MEM_WRITEDATA=0xDEADBEEF, D_READDATA=0 at completion.
- RESET pulsed in the second cycle of a GRANT_I with memory still busy -> IDLE next cycle. MEM_READ=0 and all outputs at reset values; I_BUSYWAIT stays high while I_READ is held.
- Both ports continuously requesting, latency 1 -> without macro, D granted every time and I starved. With MEM_ARB_ROUND_ROBIN_EN, grants alternate D, I, D, I.
- Memory completes in the first grant cycle (MEM_BUSYWAIT never high) -> completion in cycle 1; data returned and busywait low in that same cycle.
